// File: rtl/ecal_cmd_rx.sv
// ecal_cmd_rx: deframes the serial ECAL command line into code + payload and holds it
// in a valid/ready output buffer. Optional even-parity bit: `define ECAL_CMD_RX_PARITY_EN.
module ecal_cmd_rx #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              Din,
    output logic [3:0]        Cmd_Code,
    output logic [DATA_W-1:0] Cmd_Data,
    output logic              Cmd_Valid,
    input  logic              Cmd_Ready,
    output logic              Frame_Err,
    output logic              Overrun,
    output logic              Busy
);

    localparam int FRAME_W = 4 + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

`ifdef ECAL_CMD_RX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_STOP   = 2'd3
    } state_t;
`endif

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic [3:0]         r_cmd_code;
    logic [DATA_W-1:0]  r_cmd_data;
    logic               r_cmd_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_busy;
    logic               w_last_bit;
    logic               w_parity_ok;
    logic               w_frame_done;
    logic               w_frame_good;

`ifdef ECAL_CMD_RX_PARITY_EN
    logic               r_parity;
`endif

    assign w_last_bit   = (r_bit_cnt == CNT_W'(FRAME_W - 1));
    assign w_frame_done = (r_state == S_STOP);

`ifdef ECAL_CMD_RX_PARITY_EN
    assign w_parity_ok  = (r_parity == ^r_shift);
`else
    assign w_parity_ok  = 1'b1;
`endif

    // Din is the stop bit while in STOP; a good frame needs it low.
    assign w_frame_good = w_frame_done && !Din && w_parity_ok;

    // State register
    always_ff @(posedge Clk or negedge Rst_N) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Rst_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Din) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
`ifdef ECAL_CMD_RX_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef ECAL_CMD_RX_PARITY_EN
            S_PARITY: w_next_state = S_STOP;
`endif
            S_STOP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_bit_cnt <= '0;
        end else if (r_state == S_IDLE && Din) begin
            r_bit_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    // NOTE: the receive shifter needs no reset; every bit is overwritten before a frame is checked.
    always_ff @(posedge Clk) begin
        if (r_state == S_SHIFT) begin
            r_shift <= {r_shift[FRAME_W-2:0], Din};
        end
`ifdef ECAL_CMD_RX_PARITY_EN
        if (r_state == S_PARITY) begin
            r_parity <= Din;
        end
`endif
    end

    // Output buffer: a transfer and a new load may share one edge, giving gap-free handoff.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_cmd_code  <= '0;
            r_cmd_data  <= '0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_cmd_valid && Cmd_Ready) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_frame_done) begin
                if (!w_frame_good) begin
                    r_frame_err <= 1'b1;
                end else if (!r_cmd_valid || Cmd_Ready) begin
                    r_cmd_code  <= r_shift[FRAME_W-1 -: 4];
                    r_cmd_data  <= r_shift[DATA_W-1:0];
                    r_cmd_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end
        end
    end

    assign Cmd_Code  = r_cmd_code;
    assign Cmd_Data  = r_cmd_data;
    assign Cmd_Valid = r_cmd_valid;
    assign Frame_Err = r_frame_err;
    assign Overrun   = r_overrun;
    assign Busy      = w_busy;

endmodule
